// File: rtl/logic_eval_pkg.sv
// Shared types and defaults for the logic evaluation pipeline.
package logic_eval_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = 16;

    typedef enum logic [1:0] {
        OP_LEGACY = 2'd0,
        OP_ADD3   = 2'd1,
        OP_MUX    = 2'd2,
        OP_RSVD   = 2'd3
    } op_e;

    // Number of set bits in a vector of up to 32 bits.
    function automatic logic [5:0] popcount32(input logic [31:0] v);
        logic [5:0] n;
        n = '0;
        for (int i = 0; i < 32; i++) begin
            n = n + {5'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/logic_eval_core.sv
// Combinational per-bit operation selected by mode.
module logic_eval_core
    import logic_eval_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] d,
    input  op_e              mode,
    output logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y
);

    // Bitwise result for the selected operation; reserved mode yields zero.
    always_comb begin
        // NOTE: defaults first so every path assigns x and y and no latch is inferred.
        x = '0;
        y = '0;
        case (mode)
            OP_LEGACY: begin
                x = ~d ^ (a | s);
                y = a & s;
            end
            OP_ADD3: begin
                x = a ^ s ^ d;
                y = (a & s) | (a & d) | (s & d);
            end
            OP_MUX: begin
                x = (d & s) | (~d & a);
                y = ~(a | s | d);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/logic_eval_pipe.sv
// Two-stage valid/ready pipeline around logic_eval_core with popcount,
// parity, completed-beat counter and sticky illegal-mode flag.
module logic_eval_pipe
    import logic_eval_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           a,
    input  logic [WIDTH-1:0]           s,
    input  logic [WIDTH-1:0]           d,
    input  logic [1:0]                 mode,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           x,
    output logic [WIDTH-1:0]           y,
    output logic [$clog2(WIDTH+1)-1:0] pop_x,
    output logic                       par_x,
    output logic [CNT_W-1:0]           beat_cnt,
    output logic                       err,
    input  logic                       clr_err
);

    localparam int PW = $clog2(WIDTH+1);

    logic [WIDTH-1:0] core_x;
    logic [WIDTH-1:0] core_y;
    logic             s1_valid;
    logic [WIDTH-1:0] s1_x;
    logic [WIDTH-1:0] s1_y;
    logic             s2_adv;
    logic             in_fire;
    logic             out_fire;
    logic [PW-1:0]    s1_pop;
    logic             s1_par;

    logic_eval_core #(.WIDTH(WIDTH)) u_core (
        .a    (a),
        .s    (s),
        .d    (d),
        .mode (op_e'(mode)),
        .x    (core_x),
        .y    (core_y)
    );

    // S2 moves when empty or being drained; S1 accepts when empty or S2 moves.
    assign s2_adv   = ~out_valid | out_ready;
    assign in_ready = ~s1_valid | s2_adv;
    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    // Reduction logic between S1 and S2.
    assign s1_pop = PW'(popcount32(32'(s1_x)));
    assign s1_par = ^s1_x;

    // Pipeline registers: data only loads with a valid beat so outputs stay X-free.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: data registers are cleared too, so outputs are known straight after reset.
            s1_valid  <= 1'b0;
            s1_x      <= '0;
            s1_y      <= '0;
            out_valid <= 1'b0;
            x         <= '0;
            y         <= '0;
            pop_x     <= '0;
            par_x     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so S2 samples S1's pre-edge contents.
            if (in_ready) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_x <= core_x;
                    s1_y <= core_y;
                end
            end
            if (s2_adv) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    x     <= s1_x;
                    y     <= s1_y;
                    pop_x <= s1_pop;
                    par_x <= s1_par;
                end
            end
        end
    end

    // Completed-beat counter and sticky error flag; a new illegal beat beats a clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt <= '0;
            err      <= 1'b0;
        end else begin
            if (out_fire) begin
                beat_cnt <= beat_cnt + CNT_W'(1);
            end
            if (in_fire && (op_e'(mode) == OP_RSVD)) begin
                err <= 1'b1;
            end else if (clr_err) begin
                err <= 1'b0;
            end
        end
    end

endmodule
